cardinal_nic_buffered: RTL
==========================

Name: cardinal_nic_buffered

Overview:
- Next-generation network interface between one cardinal_cpu and its mesh router port. Replaces the single-entry NIC channels with parametrised-depth input and output FIFOs.
- Adds occupancy-reporting status registers and a sticky overflow flag.
- Injects a packet only when the packet's virtual-channel bit matches router polarity.
- Instantiated once per node in the CMP top; the top is generalised to N×N meshes.

Parameters:
- DATA_WIDTH, 64, packet/data word width; bit 0 is the MSB.
- IN_DEPTH, 4, input (network→CPU) FIFO depth; power of 2, ≥2.
- OUT_DEPTH, 4, output (CPU→network) FIFO depth; power of 2, ≥2.
- VC_BIT, 0, index of the virtual-channel bit in a packet.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- addr  in  2  CPU register select: 00 input data, 01 input status, 10 output data, 11 output status.
- d_in  in  DATA_WIDTH  CPU write data.
- d_out  out  DATA_WIDTH  CPU read data (combinational).
- nicEn  in  1  CPU access enable.
- nicEnWr  in  1  write when 1, read when 0 (valid with nicEn).
- net_si  in  1  router presents a packet.
- net_ri  out  1  NIC can accept a packet.
- net_di  in  DATA_WIDTH  packet from router.
- net_so  out  1  NIC presents a packet.
- net_ro  in  1  router can accept a packet.
- net_do  out  DATA_WIDTH  packet to router.
- net_polarity  in  1  router even/odd cycle phase.

Behaviour:
- Reset asserted: both FIFOs empty, pointers/counts 0, overflow flag 0. d_out=0, net_so=0, net_ri=0, net_do=0. Effect is immediate (asynchronous); deassertion is used synchronously.
- Network receive: net_ri = !in_full. On an edge with net_si & net_ri, net_di is pushed to the input FIFO.
- No push when the FIFO is full, even if the CPU pops in the same cycle.
- Network send: net_do = output FIFO head (0 when empty). net_so = !out_empty & net_ro & (head[VC_BIT] == net_polarity).
- The output FIFO pops on the same edge that net_so=1 is presented. Zero-latency head presentation; one packet per cycle maximum.
- CPU read (nicEn=1, nicEnWr=0), d_out combinational:
  - addr 00: input head, or 0 when empty. Pops on the edge when non-empty; a read of an empty FIFO has no effect.
  - addr 01: bit0 = input non-empty; low $clog2(IN_DEPTH)+1 bits = input count; other bits 0.
  - addr 11: bit0 = output full; bit1 = sticky overflow; low $clog2(OUT_DEPTH)+1 bits = output count; other bits 0. A read clears the overflow flag on that edge.
  - addr 10: d_out=0.
- When nicEn=0, d_out=0.
- CPU write (nicEn=1, nicEnWr=1):
  - addr 10: push d_in if output not full. If full, drop the word and set overflow. Fullness is evaluated before any same-cycle network pop.
  - Writes to other addresses are ignored.
- Simultaneous events:
  - CPU pop and network push on the input FIFO: both occur, count unchanged.
  - CPU push and network pop on the output FIFO (not full): both occur, count unchanged.
  - Overflow set and status-11 read on the same edge: cannot occur (different addr).
- Pointers wrap modulo depth. Count width is $clog2(depth)+1 so that full = count==depth.
- No combinational path from d_in to any net_* output. net_so depends combinationally on net_ro/net_polarity, matching the router contract.

Decomposition:
- Shared package cardinal_noc_pkg:
  - DATA_WIDTH default.
  - NIC address encodings (NIC_IN_DATA=2'b00, NIC_IN_STAT=2'b01, NIC_OUT_DATA=2'b10, NIC_OUT_STAT=2'b11).
  - Packet field positions: VC_BIT, direction bits, hop-count and source fields.
- One sub-module, nic_fifo (DEPTH, WIDTH):
  - Synchronous FIFO with push, pop, head, count, full and empty outputs.
  - Asynchronous active-low reset.
  - Instantiated twice, once per direction.

Test Plan:
- Reset mid-traffic: output FIFO holds 3 packets, reset pulled to 0 → net_so=0 immediately; after release, status 11 reads 0 and net_ri=1.
- Fill input FIFO: router drives 5 packets back-to-back with IN_DEPTH=4 → net_ri drops after the 4th accept. Status 01 reads count=4, bit0=1. Four CPU reads return packets in order. A 5th read of the empty FIFO returns 0 and the count stays 0.
- Polarity gating: write packet with VC bit=1, net_ro=1, net_polarity toggles 0,1 → net_so=0 in the polarity-0 cycle. Sent in the polarity-1 cycle with net_do equal to the written word.
- Overflow: 5 writes to addr 10 with net_ro=0 → status 11 shows full=1, overflow=1, count=4. A second status read shows overflow=0. The 5th word is never transmitted.
- Simultaneous push/pop: input count=2, CPU reads addr 00 while router pushes → count stays 2, FIFO order preserved.
- Wrap-around: 10 packets streamed through a depth-4 FIFO with alternating CPU reads → all received in order, pointers wrap without loss.

Source files
------------

// File: rtl/cardinal_noc_pkg.sv
// -----------------------------------------------------------------------------
// cardinal_noc_pkg
// Shared definitions for the Cardinal mesh network interface.
//   - NOC_DATA_WIDTH : default packet/data word width.
//   - nic_addr_e     : CPU-visible NIC register select encodings.
//   - PKT_*          : packet field positions. Numbering follows the packet
//                      convention where bit 0 is the MSB of the word.
// -----------------------------------------------------------------------------
package cardinal_noc_pkg;

    localparam int NOC_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        NIC_IN_DATA  = 2'b00,
        NIC_IN_STAT  = 2'b01,
        NIC_OUT_DATA = 2'b10,
        NIC_OUT_STAT = 2'b11
    } nic_addr_e;

    // Packet field positions, bit 0 = MSB of the packet word.
    localparam int PKT_VC_BIT    = 0;
    localparam int PKT_DIR_X_BIT = 1;
    localparam int PKT_DIR_Y_BIT = 2;
    localparam int PKT_HOP_MSB   = 8;
    localparam int PKT_HOP_LSB   = 15;
    localparam int PKT_SRC_MSB   = 16;
    localparam int PKT_SRC_LSB   = 31;

endpackage

// File: rtl/cardinal_nic_buffered_fifo.sv
// -----------------------------------------------------------------------------
// nic_fifo
// Synchronous FIFO used for both NIC directions.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored while full)
//   pop        : read request (ignored while empty)
//   head       : current oldest entry, zero when empty (no read latency)
//   count      : occupancy, $clog2(DEPTH)+1 bits so that full = count==DEPTH
//   full/empty : occupancy flags
// -----------------------------------------------------------------------------
module nic_fifo
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    // Occupancy flags, qualified requests and head presentation.
    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == {CW{1'b0}});
        count   = count_q;
        // Fullness is judged on the current state, so a same-cycle pop never
        // makes room for a push into a full FIFO.
        push_ok = push & ~full;
        pop_ok  = pop & ~empty;
        if (empty) begin
            head = {WIDTH{1'b0}};
        end else begin
            head = mem_q[rd_ptr_q];
        end
    end

    // Next-state for storage, pointers and count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cardinal_nic_buffered.sv
// -----------------------------------------------------------------------------
// cardinal_nic_buffered
// Buffered network interface between a cardinal_cpu and its router port.
//   clk, reset        : clock, asynchronous active-low reset
//   addr, d_in, d_out : CPU register select, write data, read data (comb.)
//   nicEn, nicEnWr    : CPU access enable and write/read select
//   net_si/ri/di      : router -> NIC packet handshake and data
//   net_so/ro/do      : NIC -> router packet handshake and data
//   net_polarity      : router even/odd phase; gates injection by VC bit
// Packet bit numbering puts bit 0 at the MSB; with the descending vectors used
// here, packet bit k lives at vector index DATA_WIDTH-1-k.
// -----------------------------------------------------------------------------
module cardinal_nic_buffered
    import cardinal_noc_pkg::*;
#(
    parameter int DATA_WIDTH = NOC_DATA_WIDTH,
    parameter int IN_DEPTH   = 4,
    parameter int OUT_DEPTH  = 4,
    parameter int VC_BIT     = PKT_VC_BIT
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicEnWr,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_polarity
);

    localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
    localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;
    localparam int MSB    = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] in_head, out_head;
    logic [IN_CW-1:0]      in_count;
    logic [OUT_CW-1:0]     out_count;
    logic                  in_full, in_empty, out_full, out_empty;
    logic                  cpu_rd, cpu_wr;
    logic                  in_push, in_pop, out_push, out_pop;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] in_stat, out_stat, rd_data;

    // Handshakes, FIFO controls and sticky overflow next-state.
    always_comb begin
        cpu_rd   = nicEn & ~nicEnWr;
        cpu_wr   = nicEn & nicEnWr;
        net_ri   = reset & ~in_full;
        in_push  = net_si & net_ri;
        in_pop   = cpu_rd & (addr == NIC_IN_DATA) & ~in_empty;
        out_push = cpu_wr & (addr == NIC_OUT_DATA) & ~out_full;
        // Inject only when the head's VC bit matches the router phase.
        net_so   = reset & ~out_empty & net_ro & (out_head[MSB-VC_BIT] == net_polarity);
        out_pop  = net_so;
        net_do   = out_head;
        if (cpu_wr && (addr == NIC_OUT_DATA) && out_full) begin
            ovf_d = 1'b1;
        end else if (cpu_rd && (addr == NIC_OUT_STAT)) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // CPU read mux; status flags sit at the packet MSB end, count at the LSB end.
    always_comb begin
        in_stat           = DATA_WIDTH'(in_count);
        in_stat[MSB]      = ~in_empty;
        out_stat          = DATA_WIDTH'(out_count);
        out_stat[MSB]     = out_full;
        out_stat[MSB-1]   = ovf_q;
        case (addr)
            NIC_IN_DATA:  rd_data = in_head;
            NIC_IN_STAT:  rd_data = in_stat;
            NIC_OUT_STAT: rd_data = out_stat;
            default:      rd_data = {DATA_WIDTH{1'b0}};
        endcase
        if (reset && cpu_rd) begin
            d_out = rd_data;
        end else begin
            d_out = {DATA_WIDTH{1'b0}};
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    nic_fifo #(.DEPTH(IN_DEPTH), .WIDTH(DATA_WIDTH)) u_in_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (in_push),
        .pop   (in_pop),
        .din   (net_di),
        .head  (in_head),
        .count (in_count),
        .full  (in_full),
        .empty (in_empty)
    );

    nic_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(DATA_WIDTH)) u_out_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (out_push),
        .pop   (out_pop),
        .din   (d_in),
        .head  (out_head),
        .count (out_count),
        .full  (out_full),
        .empty (out_empty)
    );

endmodule
